// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 recoding (N=B_W/2 steps); otherwise radix-2 (N=B_W steps).
package booth_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } recode_t;

    function automatic int num_steps(input int bw);
`ifdef BOOTH_RADIX4_EN
        return bw / 2;
`else
        return bw;
`endif
    endfunction

endpackage

// File: rtl/booth_mul_seq_enc.sv
// Radix-4 Booth recoder: {b[i+1], b[i], b[i-1]} -> {neg, two, zero}.
// Purely combinational; radix-2 callers tie bit1 to bit0 so two never asserts.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] bits,
    output recode_t    rc
);

    logic is_zero;

    assign is_zero = (bits == 3'b000) || (bits == 3'b111);
    assign rc.zero = is_zero;
    assign rc.two  = (bits == 3'b011) || (bits == 3'b100);
    assign rc.neg  = bits[2] && !is_zero;

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative signed Booth multiplier, one step per clock; N cycles from acceptance to out_valid.
// Result held while out_ready=0; in DONE in_ready follows out_ready for bubble-free reissue. Macro: BOOTH_RADIX4_EN.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int A_W = 25,
    parameter int B_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   p
);

    localparam int P_W   = A_W + B_W;
    localparam int ACC_W = P_W + 2;
    localparam int N     = num_steps(B_W);
    localparam int CNT_W = $clog2(B_W);
`ifdef BOOTH_RADIX4_EN
    localparam int SH = 2;
    if (B_W % 2 != 0) begin : g_bw_check
        $error("booth_mul_seq: B_W must be even for radix-4");
    end
`else
    localparam int SH = 1;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] m_q, m_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [B_W-1:0]   q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [P_W-1:0]   p_q, p_d;

    logic [2:0]                  enc_in;
    recode_t                     rc;
    logic [ACC_W-1:0]            term;
    logic [ACC_W-1:0]            sum;
    logic signed [ACC_W+B_W:0]   cat;
    logic signed [ACC_W+B_W:0]   shifted;
    logic                        load;

`ifdef BOOTH_RADIX4_EN
    assign enc_in = {q_q[1], q_q[0], qm1_q};
`else
    assign enc_in = {q_q[0], q_q[0], qm1_q};
`endif

    booth_r4_enc u_enc (
        .bits (enc_in),
        .rc   (rc)
    );

    // Accumulator carries two guard bits, so +-2M can never overflow it.
    assign term    = rc.zero ? '0 : (rc.two ? {m_q[ACC_W-2:0], 1'b0} : m_q);
    assign sum     = acc_q + (rc.neg ? ~term : term) + {{(ACC_W-1){1'b0}}, rc.neg};
    assign cat     = {sum, q_q, qm1_q};
    assign shifted = cat >>> SH;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        p_d       = p_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            RUN: begin
                acc_d = shifted[ACC_W+B_W:B_W+1];
                q_d   = shifted[B_W:1];
                qm1_d = shifted[0];
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    p_d     = shifted[P_W:1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) load = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = RUN;
            cnt_d   = '0;
            m_d     = {{(ACC_W-A_W){a[A_W-1]}}, a};
            q_d     = b;
            qm1_d   = 1'b0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            p_q     <= p_d;
        end
    end

    assign p = p_q;

endmodule
